// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter for 4..6 bit operands, one bit per clock via
// shift-and-add-3; results hold until the next conversion completes.
module bin2bcd_seq #(
  parameter int IN_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic [3:0]      tens,
  output logic [3:0]      units
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Three counts cover every legal IN_W (last index is at most 5).
  localparam logic [2:0] LAST_CNT = 3'(IN_W - 1);

  state_t            state_r, state_s;
  logic [IN_W-1:0]   opnd_r, opnd_s;
  logic [7:0]        bcd_r, bcd_s;
  logic [2:0]        cnt_r, cnt_s;
  logic              busy_s, done_s;
  logic [3:0]        tens_s, units_s;
  logic [7:0]        bcd_fix_s;
  logic [IN_W+7:0]   shift_s;

  function automatic logic [3:0] fix_nibble(input logic [3:0] n);
    if (n >= 4'd5) begin
      return n + 4'd3;
    end else begin
      return n;
    end
  endfunction

  // Next-state, datapath and output decode for the conversion FSM.
  always_comb begin
    bcd_fix_s = {fix_nibble(bcd_r[7:4]), fix_nibble(bcd_r[3:0])};
    shift_s   = {bcd_fix_s, opnd_r} << 4'd1;
    state_s   = state_r;
    opnd_s    = opnd_r;
    bcd_s     = bcd_r;
    cnt_s     = cnt_r;
    busy_s    = busy;
    done_s    = 1'b0;
    tens_s    = tens;
    units_s   = units;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          opnd_s  = bin_in;
          bcd_s   = 8'd0;
          cnt_s   = 3'd0;
          busy_s  = 1'b1;
          state_s = S_SHIFT;
        end else begin
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        bcd_s  = shift_s[IN_W+7:IN_W];
        opnd_s = shift_s[IN_W-1:0];
        cnt_s  = cnt_r + 3'd1;
        // The final shift's result goes straight to the outputs.
        if (cnt_r == LAST_CNT) begin
          tens_s  = shift_s[IN_W+7:IN_W+4];
          units_s = shift_s[IN_W+3:IN_W];
          done_s  = 1'b1;
          state_s = S_DONE;
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_DONE: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      opnd_r  <= '0;
      bcd_r   <= 8'd0;
      cnt_r   <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tens    <= 4'd0;
      units   <= 4'd0;
    end else begin
      state_r <= state_s;
      opnd_r  <= opnd_s;
      bcd_r   <= bcd_s;
      cnt_r   <= cnt_s;
      busy    <= busy_s;
      done    <= done_s;
      tens    <= tens_s;
      units   <= units_s;
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: IN_W, default 6, width of the unsigned binary operand; legal range 4..6 so the result always fits two BCD digits.
REQ-002 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  conversion request; sampled only in IDLE.
REQ-005 Port: bin_in  input  IN_W  unsigned binary operand; captured on the accepting edge.
REQ-006 Port: busy  output  1  high from the accepting edge until the block returns to IDLE.
REQ-007 Port: done  output  1  one-cycle pulse; tens and units are valid while high.
REQ-008 Port: tens  output  4  BCD tens digit (0..6), feeds the downstream BCD-to-5421 stage.
REQ-009 Port: units  output  4  BCD units digit (0..9), feeds the downstream BCD-to-5421 stage.

Function
REQ-010 The block SHALL convert bin_in to two BCD digits using shift-and-add-3 (double dabble), one bit per clock.
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 IDLE: if start=1 at a rising edge, the block SHALL load bin_in into the operand shift register, clear the 8-bit BCD working register and the iteration counter, set busy=1 and go to SHIFT; otherwise it SHALL stay in IDLE.
REQ-013 SHIFT: on each edge, the block SHALL add 3 to every working BCD nibble whose value is 5 or more, then shift {BCD, operand} left by one bit with the operand MSB entering BCD bit 0, and increment the counter.
REQ-014 SHIFT SHALL last exactly IN_W edges; on the IN_W-th edge the block SHALL load tens and units from the corrected, shifted working register and go to DONE.
REQ-015 DONE: done=1 and busy=1 for exactly one cycle; on the next edge the block SHALL go to IDLE with done=0 and busy=0.
REQ-016 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge E(IN_W); for IN_W=6, done is high after E6 and clears at E7.
REQ-017 The earliest next acceptance is edge E8 for IN_W=6, i.e. throughput is one conversion per IN_W+2 cycles.
REQ-018 start SHALL be ignored in SHIFT and DONE; it SHALL NOT be queued.
REQ-019 Changes on bin_in after the accepting edge SHALL NOT affect the result.
REQ-020 tens and units SHALL change only on the completion edge, and SHALL hold the last result through IDLE and the following conversion until that conversion completes.
REQ-021 Results SHALL be exact for every input 0..2^IN_W-1: tens = value/10 and units = value mod 10, with no output code above 9.

Reset
REQ-022 With rst_n=0 at a rising edge, the block SHALL go to IDLE and set busy=0, done=0, tens=0 and units=0, and clear the working registers and counter.
REQ-023 Reset SHALL take priority over start and over any state, including mid-SHIFT and DONE; an aborted conversion SHALL produce no done pulse.
REQ-024 After rst_n returns high, start SHALL be accepted on the first edge at which it is sampled high.

Verification
REQ-025 Input bin_in=0, start for one cycle -> done pulses after 6 SHIFT edges with tens=0, units=0; busy is high for exactly 7 cycles.
REQ-026 Input bin_in=63 -> tens=6, units=3; bin_in=45 -> tens=4, units=5; bin_in=9 -> tens=0, units=9.
REQ-027 Run all 64 inputs back-to-back, re-asserting start in every IDLE cycle -> each result equals value/10 and value mod 10, and done pulses are spaced 8 cycles apart.
REQ-028 Start with bin_in=37, then assert start=1 with bin_in=12 during SHIFT -> result is tens=3, units=7 and only one done pulse occurs.
REQ-029 Start with bin_in=58, then apply rst_n=0 at the third SHIFT edge -> outputs are 0 and IDLE is entered with no done pulse; a new start with bin_in=21 then gives tens=2, units=1.
REQ-030 Hold bin_in steady, then toggle it every cycle during a conversion -> the result matches the value captured at the accepting edge.
